// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (ADD/SUB/AND/OR) on unsigned WIDTH-bit operands.
// Latency is two enabled clock edges with one operation per enabled cycle; en=0 holds every register.
// Ports: clk, rst (async active-high), en, in_valid, A, B, OP -> Y, out_valid [, carry, zero].
// Optional flags: define ALU_PIPE_FLAGS_EN to add the carry/zero outputs and their registers.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] Y,
`ifdef ALU_PIPE_FLAGS_EN
  output logic             out_valid,
  output logic             carry,
  output logic             zero
`else
  output logic             out_valid
`endif
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // The flagged build carries one extra result bit: carry-out for ADD, borrow for SUB.
`ifdef ALU_PIPE_FLAGS_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  // Stage 1: operand/opcode capture
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             vld_q;

  // Stage 2: result registers
  logic [WIDTH-1:0] y_q;
  logic             ov_q;
  logic [RW-1:0]    res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      vld_q <= 1'b0;
    end else if (en) begin
      a_q   <= A;
      b_q   <= B;
      op_q  <= op_e'(OP);
      vld_q <= in_valid;
    end
  end

  // Operands are zero-extended to RW bits so the top bit of ADD/SUB is the
  // carry/borrow; the bitwise ops leave it at 0.
  always_comb begin
    res_d = '0;
    case (op_q)
      OP_ADD:  res_d = RW'(a_q) + RW'(b_q);
      OP_SUB:  res_d = RW'(a_q) - RW'(b_q);
      OP_AND:  res_d = RW'(a_q & b_q);
      OP_OR:   res_d = RW'(a_q | b_q);
      default: res_d = '0;
    endcase
  end

  // Y is updated regardless of the valid bit; only out_valid qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q  <= '0;
      ov_q <= 1'b0;
    end else if (en) begin
      y_q  <= res_d[WIDTH-1:0];
      ov_q <= vld_q;
    end
  end

  assign Y         = y_q;
  assign out_valid = ov_q;

`ifdef ALU_PIPE_FLAGS_EN
  logic carry_q, zero_q;
  logic zero_d;

  assign zero_d = (res_d[WIDTH-1:0] == '0);

  // zero resets to 0 even though an all-zero Y would compute zero=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (en) begin
      carry_q <= res_d[WIDTH];
      zero_q  <= zero_d;
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed vectors, stall, async reset and randomized traffic
// checked against a queue-based model of in-flight results.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic [W-1:0] A, B;
  logic [1:0]   OP;
  logic [W-1:0] Y;
  logic         out_valid;
`ifdef ALU_PIPE_FLAGS_EN
  logic         carry, zero;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .Y         (Y),
`ifdef ALU_PIPE_FLAGS_EN
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero)
`else
    .out_valid (out_valid)
`endif
  );

  // Expected visible output, and results of operations already sampled but not yet visible.
  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  res_t pipe_q[$];
  res_t exp_r;

  function automatic res_t compute(int a, int b, int op, bit v);
    res_t r;
    int   full;
    full = 0;
    case (op)
      0: full = a + b;
      1: full = (a >= b) ? (a - b) : (a - b + (1 << W) + (1 << W));
      2: full = a & b;
      default: full = a | b;
    endcase
    r.y = full % (1 << W);
    r.c = (full >= (1 << W));
    r.z = (r.y == 0);
    r.v = v;
    return r;
  endfunction

  // After reset the visible output is forced to zeros, and the operation waiting
  // in the pipe is the all-zero ADD that reset leaves in stage 1.
  task automatic model_reset();
    exp_r = '0;
    pipe_q.delete();
    pipe_q.push_back(compute(0, 0, 0, 1'b0));
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic drive(int a, int b, int op, bit v, bit e);
    A = a[W-1:0]; B = b[W-1:0]; OP = op[1:0]; in_valid = v; en = e;
    @(posedge clk);
    if (e) begin
      pipe_q.push_back(compute(a, b, op, v));
      exp_r = pipe_q.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; A = 8'hFF; B = 8'h01; OP = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Y !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset: Y=%h out_valid=%b, required Y=00 out_valid=0", Y, out_valid);
    end
`ifdef ALU_PIPE_FLAGS_EN
    checks++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: carry=%b zero=%b, required 0 0", carry, zero);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int   va[7] = '{10, 20, 8'hAA, 8'hAA, 255, 5, 0};
    int   vb[7] = '{5, 7, 8'hCC, 8'hCC, 1, 7, 0};
    int   vo[7] = '{0, 1, 2, 3, 0, 1, 0};
    logic [W-1:0] ey[6] = '{8'd15, 8'd13, 8'h88, 8'hEE, 8'h00, 8'hFE};
    logic ec[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ez[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], vo[i], (i < 6), 1'b1);
      if (i >= 1) begin
        checks++;
        if (Y !== ey[i-1] || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL directed[%0d]: Y=%h out_valid=%b, required Y=%h out_valid=1",
                   i-1, Y, out_valid, ey[i-1]);
        end
`ifdef ALU_PIPE_FLAGS_EN
        checks++;
        if (carry !== ec[i-1] || zero !== ez[i-1]) begin
          failures++;
          $display("FAIL directed_flags[%0d]: carry=%b zero=%b, required %b %b",
                   i-1, carry, zero, ec[i-1], ez[i-1]);
        end
`endif
      end
    end
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 1'b1, 1'b1);
    drive(3, 4, 0, 1'b1, 1'b1);
    checks++;
    if (Y !== 8'd2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_pre: Y=%h out_valid=%b, required Y=02 out_valid=1", Y, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(255), $urandom_range(255), $urandom_range(3), 1'b0, 1'b0);
      checks++;
      if (Y !== 8'd2 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: Y=%h out_valid=%b, required Y=02 out_valid=1",
                 i, Y, out_valid);
      end
    end
    drive(0, 0, 2, 1'b0, 1'b1);
    checks++;
    if (Y !== 8'd7 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: Y=%h out_valid=%b, required Y=07 out_valid=1", Y, out_valid);
    end
    drive(0, 0, 2, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(9, 9, 0, 1'b1, 1'b1);
    drive(8, 1, 1, 1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (Y !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: Y=%h out_valid=%b, required Y=00 out_valid=0", Y, out_valid);
    end
`ifdef ALU_PIPE_FLAGS_EN
    checks++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL arst_flags: carry=%b zero=%b, required 0 0", carry, zero);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 3, 1'b0, 1'b1);
    drive(6, 2, 1, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || Y !== exp_r.y) begin
      failures++;
      $display("FAIL arst_no_stale: Y=%h out_valid=%b, required Y=%h out_valid=0",
               Y, out_valid, exp_r.y);
    end
    drive(0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (Y !== 8'd4 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_first: Y=%h out_valid=%b, required Y=04 out_valid=1", Y, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(255), $urandom_range(255), $urandom_range(3),
            $urandom_range(1), ($urandom_range(4) != 0));
      checks++;
      if (Y !== exp_r.y || out_valid !== exp_r.v) begin
        failures++;
        $display("FAIL random[%0d]: Y=%h out_valid=%b, required Y=%h out_valid=%b",
                 n, Y, out_valid, exp_r.y, exp_r.v);
      end
`ifdef ALU_PIPE_FLAGS_EN
      checks++;
      if (carry !== exp_r.c || zero !== exp_r.z) begin
        failures++;
        $display("FAIL random_flags[%0d]: carry=%b zero=%b, required %b %b",
                 n, carry, zero, exp_r.c, exp_r.z);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and is the asynchronous, active-high reset.
REQ-004 Port en SHALL be an input, 1 bit wide, and is the pipeline advance enable; when it is 0 every register holds.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and marks the current A/B/OP as a real operation.
REQ-006 Port A SHALL be an input, WIDTH bits wide, and is operand A (unsigned).
REQ-007 Port B SHALL be an input, WIDTH bits wide, and is operand B (unsigned).
REQ-008 Port OP SHALL be an input, 2 bits wide, and is the opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 Port Y SHALL be an output, WIDTH bits wide, and is the registered result.
REQ-010 Port out_valid SHALL be an output, 1 bit wide, and is the registered in_valid aligned with Y.
REQ-011 Ports carry and zero SHALL be outputs, 1 bit wide each, and are the registered flags; they exist only under ALU_PIPE_FLAGS_EN.

Function
REQ-012 Stage 1 SHALL register A, B, OP and in_valid on each rising clk edge where en=1.
REQ-013 Stage 2 SHALL compute from the stage-1 registers and register Y, out_valid and the flags on each rising clk edge where en=1.
REQ-014 Latency SHALL be exactly 2 enabled clock edges from input sample to Y; throughput is one operation per enabled cycle.
REQ-015 ADD SHALL give Y=(A+B) mod 2^WIDTH, with carry = carry-out of bit WIDTH-1.
REQ-016 SUB SHALL give Y=(A-B) mod 2^WIDTH, with carry = borrow, i.e. 1 when A<B unsigned.
REQ-017 AND and OR SHALL be bitwise, with carry=0.
REQ-018 zero SHALL be 1 exactly when the registered Y is all zeros.
REQ-019 Y and the flags SHALL be computed and updated whether in_valid is 0 or 1; only out_valid marks meaningful data.
REQ-020 When en=0, both stages SHALL hold all values, including out_valid; inputs presented while en=0 are ignored.
REQ-021 Outputs SHALL be driven only from registers, with no combinational path from any input to any output.

Reset
REQ-022 While rst=1, all stage-1 and stage-2 registers SHALL be 0 immediately, independent of clk: Y=0, out_valid=0, carry=0, zero=0.
REQ-023 Asserting rst mid-stream SHALL discard all in-flight operations; the first valid result after release appears 2 enabled edges after its inputs are sampled.
REQ-024 The zero output SHALL read 0 during reset (a forced register value, not the computed flag).

Configuration
REQ-025 With macro ALU_PIPE_FLAGS_EN defined, the carry and zero ports and their logic SHALL be present as specified above.
REQ-026 Without ALU_PIPE_FLAGS_EN, the carry and zero ports and their registers SHALL be absent, and Y/out_valid behaviour SHALL be unchanged.

Verification (WIDTH=8, en=1, in_valid=1, rst released, 10 ns clock)
REQ-027 A=10, B=5, OP=00 -> two edges later Y=15, carry=0, zero=0, out_valid=1.
REQ-028 Back-to-back inputs, one per cycle: (20,7,01), then (0xAA,0xCC,10), then (0xAA,0xCC,11) -> on consecutive cycles Y=13, then 0x88, then 0xEE.
REQ-029 Boundaries: (255,1,00) -> Y=0, carry=1, zero=1; (5,7,01) -> Y=0xFE, carry=1.
REQ-030 en held low for 3 cycles with an operation in flight -> Y and out_valid frozen; the result emerges after en returns high.
REQ-031 rst pulsed asynchronously between clock edges with 2 operations in flight -> Y=0 and out_valid=0 at once, and no stale result appears after release.
